// File: rtl/icache_direct_pkg.sv
// ----------------------------------------------------------------------------
// icache_direct_pkg : shared constants, state encoding and width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package icache_direct_pkg;

  localparam int OFFSET_W = 2;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;

  typedef logic [0:0] state_t;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int addr_w, input int lines);
    return addr_w - OFFSET_W - $clog2(lines);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_direct_if.sv
// ----------------------------------------------------------------------------
// icache_direct_if : core fetch port and refill port of the instruction cache
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface icache_direct_if
  import icache_direct_pkg::*;
#(
  parameter int ADDR_W = 30
);

  logic                         proc_read;
  logic [ADDR_W-1:0]            proc_addr;
  logic [WORD_W-1:0]            proc_rdata;
  logic                         proc_stall;
  logic                         mem_read;
  logic [ADDR_W-OFFSET_W-1:0]   mem_addr;
  logic [LINE_W-1:0]            mem_rdata;
  logic                         mem_ready;

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/icache_direct_line_store.sv
// ----------------------------------------------------------------------------
// icache_line_store : valid/tag/data arrays, async read, sync write
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache_line_store
  import icache_direct_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_line_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_line_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/icache_direct.sv
// ----------------------------------------------------------------------------
// icache_direct : direct-mapped read-only I-cache, 4-word line refill, perf counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINES  = 8,
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  icache_direct_if.slave   bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int INDEX_W = index_width(LINES);
  localparam int TAG_W   = tag_width(ADDR_W, LINES);
  localparam int LADDR_W = ADDR_W - OFFSET_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               mem_read_q, mem_read_d;
  logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                idle, hit, lookup_hit, lookup_miss, refill;

  assign req_off = bus.proc_addr[OFFSET_W-1:0];
  assign req_idx = bus.proc_addr[OFFSET_W +: INDEX_W];
  assign req_tag = bus.proc_addr[ADDR_W-1 -: TAG_W];

  // The latched line address doubles as the refill target: low bits are the
  // index, high bits the tag, so a moving proc_addr cannot misdirect a refill.
  icache_line_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .we_i       (refill),
    .wr_idx_i   (mem_addr_q[INDEX_W-1:0]),
    .wr_tag_i   (mem_addr_q[LADDR_W-1 -: TAG_W]),
    .wr_line_i  (bus.mem_rdata)
  );

  assign idle        = (state_q == S_IDLE);
  assign hit         = rd_valid & (rd_tag == req_tag);
  assign lookup_hit  = idle & bus.proc_read & hit;
  assign lookup_miss = idle & bus.proc_read & ~hit;
  assign refill      = ~idle & bus.mem_ready;

  always_comb begin
    state_d    = state_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lookup_hit && !(&hit_cnt_q)) begin
          hit_cnt_d = hit_cnt_q + CNT_ONE;
        end
        if (lookup_miss) begin
          state_d    = S_FETCH;
          mem_read_d = 1'b1;
          mem_addr_d = bus.proc_addr[ADDR_W-1:OFFSET_W];
          if (!(&miss_cnt_q)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
          end
        end
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d    = S_IDLE;
          mem_read_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.proc_rdata = lookup_hit ? rd_line[WORD_W*req_off +: WORD_W] : '0;
  assign bus.proc_stall = idle ? lookup_miss : 1'b1;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = mem_addr_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_direct.sv
// ----------------------------------------------------------------------------
// tb_icache_direct : directed and random checks of icache_direct against a line-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_icache_direct;

  localparam int LINES  = 8;
  localparam int ADDR_W = 30;
  // Narrow counters so saturation is reached within the random phase.
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  icache_direct_if #(.ADDR_W(ADDR_W)) bus ();

  icache_direct #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: one entry per index, remembering which line address it holds.
  logic         m_valid [LINES];
  logic [27:0]  m_laddr [LINES];
  logic [127:0] m_data  [LINES];
  int           m_hits, m_miss;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      l[32*k +: 32] = (32'(la) * 32'd4 + 32'(k) + 32'd1) * 32'h9E37_79B9;
    end
    return l;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  initial begin
    logic [29:0]  a;
    logic [27:0]  la;
    int           idx, lat;
    logic [127:0] line;

    rst_n = 1'b0;
    bus.proc_read = 1'b0;
    bus.proc_addr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) tick();
    #2;
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_stall", bus.proc_stall, 0);
    rst_n = 1'b1;
    tick();

    // Cold miss on address 0, memory answers in cycle 4.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'd0;
    #2;
    chk("cold_stall_c0", bus.proc_stall, 1);
    chk("cold_mem_read_c0", bus.mem_read, 0);
    tick(); #2;
    chk("cold_mem_read_c1", bus.mem_read, 1);
    chk("cold_mem_addr_c1", bus.mem_addr, 0);
    chk("cold_miss_cnt_c1", miss_cnt, 1);
    tick(); tick(); tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
    #2;
    chk("cold_stall_c4", bus.proc_stall, 1);
    tick();
    bus.mem_ready = 1'b0;
    #2;
    chk("cold_stall_c5", bus.proc_stall, 0);
    chk("cold_rdata_c5", bus.proc_rdata, 32'hA);
    chk("cold_miss_cnt_c5", miss_cnt, 1);
    chk("cold_mem_read_c5", bus.mem_read, 0);

    for (int k = 1; k < 4; k++) begin
      tick();
      bus.proc_addr = 30'(k);
      #2;
      chk("hit_stall", bus.proc_stall, 0);
      chk("hit_rdata", bus.proc_rdata, 32'hA + 32'(k));
      chk("hit_cnt", hit_cnt, 128'(k));
      chk("hit_mem_read", bus.mem_read, 0);
    end

    // Address 32 shares index 0 with address 0 but carries tag 1.
    tick();
    bus.proc_addr = 30'd32;
    #2;
    chk("conf_stall", bus.proc_stall, 1);
    tick(); #2;
    chk("conf_mem_addr", bus.mem_addr, 8);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    tick();
    bus.mem_ready = 1'b0;
    #2;
    chk("conf_rdata", bus.proc_rdata, 32'h1111);
    chk("conf_miss_cnt", miss_cnt, 2);
    tick();
    bus.proc_addr = 30'd0;
    #2;
    chk("evict_stall", bus.proc_stall, 1);
    tick(); #2;
    chk("evict_mem_addr", bus.mem_addr, 0);
    chk("evict_mem_read", bus.mem_read, 1);
    chk("evict_miss_cnt", miss_cnt, 3);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
    tick();
    bus.mem_ready = 1'b0;
    #2;
    chk("evict_rdata", bus.proc_rdata, 32'hA);

    // Idle cycle with a stray mem_ready must not touch the arrays or counters.
    tick();
    bus.proc_read = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '1;
    #2;
    chk("idle_stall", bus.proc_stall, 0);
    chk("idle_rdata", bus.proc_rdata, 0);
    chk("idle_hit_cnt", hit_cnt, 6);
    chk("idle_miss_cnt", miss_cnt, 3);
    tick();
    bus.mem_ready = 1'b0;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'd0;
    #2;
    chk("late_ready_stall", bus.proc_stall, 0);
    chk("late_ready_rdata", bus.proc_rdata, 32'hA);
    chk("late_ready_hit_cnt", hit_cnt, 6);
    chk("late_ready_mem_read", bus.mem_read, 0);

    // Reset two cycles after mem_read rises.
    tick();
    bus.proc_addr = 30'd4;
    #2;
    chk("rstf_stall", bus.proc_stall, 1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rstf_mem_read", bus.mem_read, 0);
    chk("rstf_mem_addr", bus.mem_addr, 0);
    chk("rstf_miss_cnt", miss_cnt, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mem_line(28'd1);
    tick();
    rst_n = 1'b1;
    bus.proc_read = 1'b0;
    tick();
    bus.mem_ready = 1'b0;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'd0;
    #2;
    chk("rstf_re_stall", bus.proc_stall, 1);
    tick(); #2;
    chk("rstf_re_miss_cnt", miss_cnt, 1);
    chk("rstf_re_mem_read", bus.mem_read, 1);
    chk("rstf_re_mem_addr", bus.mem_addr, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mem_line(28'd0);
    tick();
    bus.mem_ready = 1'b0;
    #2;
    line = mem_line(28'd0);
    chk("rstf_re_rdata", bus.proc_rdata, line[31:0]);

    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_valid[0] = 1'b1;
    m_laddr[0] = 28'd0;
    m_data[0]  = line;
    m_hits = 1;
    m_miss = 1;

    // Random phase: a small address pool keeps both hits and conflicts frequent.
    for (int op = 0; op < 600; op++) begin
      tick();
      a   = 30'($urandom_range(0, 127));
      la  = a[29:2];
      idx = int'(la) % LINES;
      bus.proc_read = ($urandom_range(0, 9) != 0);
      bus.proc_addr = a;
      bus.mem_ready = 1'b0;
      if (!bus.proc_read && $urandom_range(0, 1) == 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 128'($urandom);
      end
      #2;
      chk("rnd_hit_cnt", hit_cnt, 128'(sat(m_hits)));
      chk("rnd_miss_cnt", miss_cnt, 128'(sat(m_miss)));
      if (!bus.proc_read) begin
        chk("rnd_idle_stall", bus.proc_stall, 0);
        chk("rnd_idle_rdata", bus.proc_rdata, 0);
      end else if (m_valid[idx] && m_laddr[idx] == la) begin
        chk("rnd_hit_stall", bus.proc_stall, 0);
        chk("rnd_hit_rdata", bus.proc_rdata, m_data[idx][32*a[1:0] +: 32]);
        m_hits++;
      end else begin
        chk("rnd_miss_stall", bus.proc_stall, 1);
        m_miss++;
        tick(); #2;
        chk("rnd_miss_mem_read", bus.mem_read, 1);
        chk("rnd_miss_mem_addr", bus.mem_addr, 128'(la));
        lat = $urandom_range(0, 3);
        for (int w = 0; w < lat; w++) begin
          bus.proc_read = 1'($urandom_range(0, 1));
          tick();
        end
        bus.proc_read = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_line(la);
        #2;
        chk("rnd_fetch_stall", bus.proc_stall, 1);
        tick();
        bus.mem_ready = 1'b0;
        m_valid[idx] = 1'b1;
        m_laddr[idx] = la;
        m_data[idx]  = mem_line(la);
        #2;
        chk("rnd_refill_stall", bus.proc_stall, 0);
        chk("rnd_refill_rdata", bus.proc_rdata, m_data[idx][32*a[1:0] +: 32]);
        m_hits++;
      end
    end

    tick();
    bus.proc_read = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    chk("sat_hit_cnt", hit_cnt, 128'(sat(m_hits)));
    chk("sat_miss_cnt", miss_cnt, 128'(sat(m_miss)));
    chk("sat_hit_all_ones", hit_cnt, 128'(CMAX));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
